mod_blk_serializer: RTL and testbench
=====================================

Name: mod_blk_serializer

Overview:
- Parametrised successor of the 16-to-4 output register in the AES256 datapath.
- Captures a full cipher block of NBYTES bytes in one cycle and drains it as NBYTES/OUT_BYTES words toward the AXI output interface.
- NBUF slots (ping-pong when NBUF=2) let the next block load while the current one drains.
- Adds per-word valid and last-word flags, plus a write-ready signal.

Parameters:
- NBYTES, 16: bytes per input block; must be a multiple of OUT_BYTES.
- OUT_BYTES, 4: bytes per output word.
- NBUF, 2: number of block slots, legal values 1 or 2.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- i  input  NBYTES*8  input block; byte k = i[8*k +: 8].
- wr_en  input  1  load request; accepted only when wr_ready=1.
- wr_ready  output  1  at least one free slot (count < NBUF).
- req_axi_out  input  1  request for the next output word.
- o  output  OUT_BYTES*8  registered output word.
- o_valid  output  1  one-cycle pulse: o carries a new word.
- o_last  output  1  high with o_valid on the final word of a block.
- reg_empty  output  1  all slots empty (count == 0).

Behaviour:
- Constants:
  - WPB = NBYTES/OUT_BYTES.
  - Word counter n_rd is max($clog2(WPB),1) bits wide.
  - Slot pointers wr_ptr and rd_ptr are 1 bit wide; they are tied to 0 when NBUF=1.
  - count ranges 0..NBUF.
- Reset (async, resetn=0): all slot storage = 0, o = 0, o_valid = 0, o_last = 0, n_rd = 0, pointers = 0, count = 0, reg_empty = 1, wr_ready = 1. Reset mid-drain discards all buffered data; no further o_valid until a new load.
- wr_ready and reg_empty are combinational decodes of registered count only; there is no same-cycle bypass.
- Load: on a clock edge with wr_en=1 and count < NBUF:
  - slot[wr_ptr] <= i.
  - wr_ptr toggles (NBUF=2 only).
  - wr_en with count == NBUF is ignored and the data is dropped.
- Drain: on a clock edge with req_axi_out=1 and count > 0:
  - o[8*j +: 8] <= slot[rd_ptr] byte (n_rd*OUT_BYTES + j), for j = 0..OUT_BYTES-1.
  - o_valid <= 1.
  - o_last <= (n_rd == WPB-1).
  - If n_rd == WPB-1: n_rd <= 0 and rd_ptr toggles; the slot is freed.
  - Otherwise n_rd <= n_rd + 1.
- Latency: the word appears on o one cycle after the request edge.
- If req_axi_out=1 with count==0: o holds its value, o_valid=0, o_last=0.
- Without a drain, o_valid and o_last return to 0 on the next edge; o holds its last value.
- Simultaneous load and final-word drain:
  - count stays unchanged if the load is accepted.
  - With count==NBUF at that edge, the load is rejected, because wr_ready was 0 before the edge.
- Simultaneous load and non-final drain: both take effect and count increments.
- Drain order: blocks leave in load order (FIFO); words of a block leave in ascending byte order.
- No internal states beyond count, pointers and n_rd; a partially drained block cannot be overwritten.

Optional Feature:
- Macro: MOD_BLK_SER_FLUSH_EN.
- Defined:
  - Extra input port flush (1 bit).
  - flush=1 at an edge sets count=0, pointers=0, n_rd=0, o_valid=0, o_last=0. o holds its value.
  - flush has priority over simultaneous wr_en and req_axi_out; both are ignored in that cycle.
- Undefined: the port is absent and the logic is identical to the above with flush tied to 0.

Decomposition:
- Package mod_blk_ser_pkg holds:
  - a function computing WPB and the counter width from NBYTES and OUT_BYTES;
  - the default values for NBYTES, OUT_BYTES and NBUF;
  - a byte typedef (logic [7:0]).
- Elaboration-time check: NBYTES % OUT_BYTES == 0 and NBUF in {1,2}, otherwise $error.
- One natural sub-module: mod_blk_ser_occ. It owns wr_ptr, rd_ptr, count, wr_ready and reg_empty, and takes load/free strobes as inputs.
- Storage and word mux stay in the top module.

Test Plan:
- Defaults, load i = bytes 0x00..0x0F, then 4 back-to-back requests -> o = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. o_valid is high for 4 cycles; o_last is high only on 0x0F0E0D0C; reg_empty returns to 1.
- Load A=0x00..0x0F and B=0x10..0x1F on consecutive cycles:
  - wr_ready drops to 0 after B.
  - A third load C is ignored.
  - 8 requests yield the A words then B words (0x13121110..0x1F1E1D1C).
  - No C data ever appears.
- Count=2 with final A word requested and wr_en on the same edge -> load rejected. Next cycle wr_ready=1, and a load then succeeds and drains after B.
- Assert resetn=0 after 2 of 4 words of a loaded block -> o=0, o_valid=0, reg_empty=1. Subsequent requests produce nothing until a new load.
- NBYTES=32, OUT_BYTES=8, NBUF=1, load 0x00..0x1F -> 4 words, the first 0x0706050403020100, o_last on 0x1F1E..18. A second load while draining is ignored.
- With MOD_BLK_SER_FLUSH_EN: flush after 1 word of A, with B also queued -> count=0 and reg_empty=1. Requests yield nothing; a new load of 0x20..0x2F drains from 0x23222120.

Source files
------------

// File: rtl/mod_blk_ser_pkg.sv
// Shared definitions for the block serializer: default geometry,
// a byte type, and helpers that derive words-per-block and the
// word counter width from the block and word sizes.
package mod_blk_ser_pkg;

    localparam int DEF_NBYTES    = 16;
    localparam int DEF_OUT_BYTES = 4;
    localparam int DEF_NBUF      = 2;

    typedef logic [7:0] byte_t;

    // Number of output words needed to drain one block.
    function automatic int calc_wpb(input int nbytes, input int out_bytes);
        return nbytes / out_bytes;
    endfunction

    // Word counter width; never narrower than one bit.
    function automatic int calc_cnt_w(input int nbytes, input int out_bytes);
        int wpb;
        wpb = calc_wpb(nbytes, out_bytes);
        return (wpb > 1) ? $clog2(wpb) : 1;
    endfunction

endpackage

// File: rtl/mod_blk_ser_occ.sv
// Slot occupancy tracker for the block serializer. Owns the write and
// read slot pointers and the fill count, and decodes wr_ready and
// reg_empty from the registered count only. Pointers stay at 0 for a
// single-slot build.
module mod_blk_ser_occ
    import mod_blk_ser_pkg::*;
#(
    parameter int NBUF = DEF_NBUF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_flush,
    input  logic       i_load,
    input  logic       i_free,
    output logic       o_wr_ptr,
    output logic       o_rd_ptr,
    output logic [1:0] o_count,
    output logic       o_wr_ready,
    output logic       o_reg_empty
);

    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // Fill count: +1 on an accepted load, -1 when the last word of a block leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, i_load} - {1'b0, i_free};
        end
    end

    // Slot pointers toggle on load/free; only meaningful with two slots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (NBUF == 2) begin
            if (i_load) r_wr_ptr <= ~r_wr_ptr;
            if (i_free) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_count     = r_count;
    assign o_wr_ready  = (r_count < 2'(NBUF));
    assign o_reg_empty = (r_count == 2'd0);

endmodule

// File: rtl/mod_blk_serializer.sv
// Block serializer: captures an NBYTES-byte block in one cycle into one
// of NBUF slots and drains it as OUT_BYTES-wide words, lowest bytes
// first, one word per request. Blocks leave in load order.
// Optional synchronous flush port: define MOD_BLK_SER_FLUSH_EN.
module mod_blk_serializer
    import mod_blk_ser_pkg::*;
#(
    parameter int NBYTES    = DEF_NBYTES,
    parameter int OUT_BYTES = DEF_OUT_BYTES,
    parameter int NBUF      = DEF_NBUF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NBYTES*8-1:0]    i,
    input  logic                   wr_en,
    output logic                   wr_ready,
    input  logic                   req_axi_out,
`ifdef MOD_BLK_SER_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [OUT_BYTES*8-1:0] o,
    output logic                   o_valid,
    output logic                   o_last,
    output logic                   reg_empty
);

    localparam int WPB   = calc_wpb(NBYTES, OUT_BYTES);
    localparam int CW    = calc_cnt_w(NBYTES, OUT_BYTES);
    localparam int OUT_W = OUT_BYTES * 8;
    localparam int BLK_W = NBYTES * 8;

    if ((NBYTES % OUT_BYTES) != 0 || (NBUF != 1 && NBUF != 2)) begin : g_bad_cfg
        $error("mod_blk_serializer: NBYTES must be a multiple of OUT_BYTES and NBUF must be 1 or 2");
    end

    logic             w_flush;
    logic             w_wr_ptr;
    logic             w_rd_ptr;
    logic [1:0]       w_count;
    logic             w_wr_ready;
    logic             w_reg_empty;
    logic             w_final;
    logic             w_drain;
    logic             w_load;
    logic             w_free;
    logic [BLK_W-1:0] w_blk;
    byte_t            w_bytes [NBYTES];
    logic [OUT_W-1:0] w_word;

    logic [OUT_W-1:0] r_o;
    logic             r_o_valid;
    logic             r_o_last;
    logic [CW-1:0]    r_n_rd;

`ifdef MOD_BLK_SER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A load is accepted only when a slot was free before the edge;
    // flush overrides both load and drain.
    assign w_final = (r_n_rd == CW'(WPB - 1));
    assign w_drain = req_axi_out & ~w_reg_empty & ~w_flush;
    assign w_free  = w_drain & w_final;
    assign w_load  = wr_en & w_wr_ready & ~w_flush;

    mod_blk_ser_occ #(
        .NBUF (NBUF)
    ) u_occ (
        .clk         (clk),
        .resetn      (resetn),
        .i_flush     (w_flush),
        .i_load      (w_load),
        .i_free      (w_free),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (w_count),
        .o_wr_ready  (w_wr_ready),
        .o_reg_empty (w_reg_empty)
    );

    // One register per slot; written only when the write pointer selects it.
    for (genvar gi = 0; gi < NBUF; gi++) begin : g_slot
        logic [BLK_W-1:0] r_data;

        // Capture the incoming block into this slot on an accepted load.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_data <= '0;
            end else if (w_load && (w_wr_ptr == 1'(gi))) begin
                r_data <= i;
            end
        end
    end

    if (NBUF == 2) begin : g_rd_two
        assign w_blk = w_rd_ptr ? g_slot[NBUF-1].r_data : g_slot[0].r_data;
    end else begin : g_rd_one
        assign w_blk = g_slot[0].r_data;
    end

    // Byte view of the slot being drained.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign w_bytes[gi] = w_blk[8*gi +: 8];
    end

    // Word mux: word n_rd is bytes n_rd*OUT_BYTES .. n_rd*OUT_BYTES+OUT_BYTES-1.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < WPB; k++) begin
            if (r_n_rd == CW'(k)) begin
                for (int j = 0; j < OUT_BYTES; j++) begin
                    w_word[8*j +: 8] = w_bytes[k*OUT_BYTES + j];
                end
            end
        end
    end

    // Output word register, valid/last pulses and word counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_n_rd    <= '0;
        end else if (w_flush) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_n_rd    <= '0;
        end else if (w_drain) begin
            r_o       <= w_word;
            r_o_valid <= 1'b1;
            r_o_last  <= w_final;
            r_n_rd    <= w_final ? '0 : r_n_rd + 1'b1;
        end else begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
        end
    end

    assign o         = r_o;
    assign o_valid   = r_o_valid;
    assign o_last    = r_o_last;
    assign wr_ready  = w_wr_ready;
    assign reg_empty = w_reg_empty;

endmodule

// File: tb/tb_mod_blk_serializer.sv
// Testbench for mod_blk_serializer: default 16/4/2 instance plus a
// 32/8/1 instance. Expected words go into per-instance queues when
// blocks are loaded and are compared as o_valid words appear.
module tb_mod_blk_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry instance
    logic          rstn0 = 1'b0;
    logic [127:0]  i0 = '0;
    logic          wr_en0 = 1'b0, req0 = 1'b0, flush0 = 1'b0;
    logic [31:0]   o0;
    logic          ov0, ol0, wrdy0, emp0;

    // 32-byte / 8-byte / single-slot instance
    logic          rstn1 = 1'b0;
    logic [255:0]  i1 = '0;
    logic          wr_en1 = 1'b0, req1 = 1'b0, flush1 = 1'b0;
    logic [63:0]   o1;
    logic          ov1, ol1, wrdy1, emp1;

    mod_blk_serializer u_dut0 (
        .clk         (clk),
        .resetn      (rstn0),
        .i           (i0),
        .wr_en       (wr_en0),
        .wr_ready    (wrdy0),
        .req_axi_out (req0),
`ifdef MOD_BLK_SER_FLUSH_EN
        .flush       (flush0),
`endif
        .o           (o0),
        .o_valid     (ov0),
        .o_last      (ol0),
        .reg_empty   (emp0)
    );

    mod_blk_serializer #(.NBYTES(32), .OUT_BYTES(8), .NBUF(1)) u_dut1 (
        .clk         (clk),
        .resetn      (rstn1),
        .i           (i1),
        .wr_en       (wr_en1),
        .wr_ready    (wrdy1),
        .req_axi_out (req1),
`ifdef MOD_BLK_SER_FLUSH_EN
        .flush       (flush1),
`endif
        .o           (o1),
        .o_valid     (ov1),
        .o_last      (ol1),
        .reg_empty   (emp1)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [127:0] blk;
        logic [31:0]  w0;
        logic [31:0]  w3;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   nval0    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d, input logic last);
        exp_t e;
        e.data = 64'(d);
        e.last = last;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [63:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        q1.push_back(e);
    endtask

    // Reference model: word k of a 16-byte block is bytes 4k..4k+3, little-endian.
    task automatic push_blk0(input logic [127:0] b);
        for (int k = 0; k < 4; k++) push0(b[32*k +: 32], (k == 3));
    endtask

    function automatic logic [255:0] mkblk(input logic [7:0] base, input int n);
        logic [255:0] b;
        b = '0;
        for (int k = 0; k < n; k++) b[8*k +: 8] = base + 8'(k);
        return b;
    endfunction

    task automatic load0(input logic [127:0] b);
        i0 = b;
        wr_en0 = 1'b1;
        cyc();
        wr_en0 = 1'b0;
    endtask

    task automatic req0_n(input int n);
        req0 = 1'b1;
        repeat (n) cyc();
        req0 = 1'b0;
    endtask

    // Scoreboard monitors: one line per output word.
    always @(negedge clk) begin
        if (ov0) begin
            exp_t e;
            nval0++;
            $display("u0 word o=%h last=%b", o0, ol0);
            if (q0.size() == 0) begin
                chk("u0_spurious_valid", 64'(ov0), 64'(0));
            end else begin
                e = q0.pop_front();
                chk("u0_word", 64'(o0), e.data);
                chk("u0_last", 64'(ol0), 64'(e.last));
            end
        end
        if (ov1) begin
            exp_t e;
            $display("u1 word o=%h last=%b", o1, ol1);
            if (q1.size() == 0) begin
                chk("u1_spurious_valid", 64'(ov1), 64'(0));
            end else begin
                e = q1.pop_front();
                chk("u1_word", o1, e.data);
                chk("u1_last", 64'(ol1), 64'(e.last));
            end
        end
    end

    initial begin
        vec_t         tbl [4];
        logic [255:0] t256;
        logic [127:0] blk_a, blk_b, blk_c;
        int           v;

        t256 = mkblk(8'hF0, 16);
        tbl[0] = '{blk: 128'h0F0E0D0C_0B0A0908_07060504_03020100, w0: 32'h03020100, w3: 32'h0F0E0D0C};
        tbl[1] = '{blk: t256[127:0], w0: 32'hF3F2F1F0, w3: 32'hFFFEFDFC};
        tbl[2] = '{blk: {16{8'hAA}}, w0: 32'hAAAAAAAA, w3: 32'hAAAAAAAA};
        tbl[3] = '{blk: 128'h01234567_89ABCDEF_FEDCBA98_76543210, w0: 32'h76543210, w3: 32'h01234567};

        // Reset state
        #12;
        chk("rst_o", 64'(o0), 64'(0));
        chk("rst_valid", 64'(ov0), 64'(0));
        chk("rst_last", 64'(ol0), 64'(0));
        chk("rst_empty", 64'(emp0), 64'(1));
        chk("rst_wr_ready", 64'(wrdy0), 64'(1));
        chk("rst1_empty", 64'(emp1), 64'(1));
        rstn0 = 1'b1;
        rstn1 = 1'b1;
        cyc();

        // Table: load one block, drain it with four back-to-back requests
        for (int t = 0; t < 4; t++) begin
            load0(tbl[t].blk);
            chk("tbl_ready_after_load", 64'(wrdy0), 64'(1));
            chk("tbl_not_empty", 64'(emp0), 64'(0));
            push0(tbl[t].w0, 1'b0);
            push0(tbl[t].blk[32 +: 32], 1'b0);
            push0(tbl[t].blk[64 +: 32], 1'b0);
            push0(tbl[t].w3, 1'b1);
            v = nval0;
            req0_n(4);
            cyc();
            chk("tbl_valid_cycles", 64'(nval0 - v), 64'(4));
            chk("tbl_empty_after", 64'(emp0), 64'(1));
        end

        // Two blocks fill both slots; a third load is dropped
        t256 = mkblk(8'h00, 16); blk_a = t256[127:0];
        t256 = mkblk(8'h10, 16); blk_b = t256[127:0];
        t256 = mkblk(8'hC0, 16); blk_c = t256[127:0];
        i0 = blk_a; wr_en0 = 1'b1; cyc();
        i0 = blk_b; cyc();
        wr_en0 = 1'b0;
        chk("full_wr_ready", 64'(wrdy0), 64'(0));
        load0(blk_c);
        chk("full_still_not_ready", 64'(wrdy0), 64'(0));
        push_blk0(blk_a);
        push_blk0(blk_b);
        req0_n(8);
        cyc();
        chk("ab_empty", 64'(emp0), 64'(1));
        req0_n(4);
        cyc();
        chk("idle_req_o_holds", 64'(o0), 64'(32'h1F1E1D1C));
        chk("idle_req_no_valid", 64'(ov0), 64'(0));

        // Full + final-word drain + load on one edge: load rejected
        i0 = blk_a; wr_en0 = 1'b1; cyc();
        i0 = blk_b; cyc();
        wr_en0 = 1'b0;
        push_blk0(blk_a);
        push_blk0(blk_b);
        req0_n(3);
        t256 = mkblk(8'h30, 16);
        i0 = t256[127:0]; wr_en0 = 1'b1; req0 = 1'b1;
        cyc();
        wr_en0 = 1'b0; req0 = 1'b0;
        chk("rej_ready_next", 64'(wrdy0), 64'(1));
        load0(t256[127:0]);
        chk("rej_reload_full", 64'(wrdy0), 64'(0));
        push_blk0(t256[127:0]);
        req0_n(8);
        cyc();
        chk("rej_empty", 64'(emp0), 64'(1));

        // Load with non-final drain, then load with final drain at count 1
        load0(blk_a);
        push_blk0(blk_a);
        push_blk0(blk_b);
        i0 = blk_b; wr_en0 = 1'b1; req0 = 1'b1;
        cyc();
        wr_en0 = 1'b0;
        chk("nonfinal_load_full", 64'(wrdy0), 64'(0));
        repeat (3) cyc();
        chk("a_done_one_left", 64'(wrdy0), 64'(1));
        repeat (3) cyc();
        t256 = mkblk(8'h60, 16);
        push_blk0(t256[127:0]);
        i0 = t256[127:0]; wr_en0 = 1'b1;
        cyc();
        wr_en0 = 1'b0; req0 = 1'b0;
        chk("final_load_count1_ready", 64'(wrdy0), 64'(1));
        chk("final_load_count1_nonempty", 64'(emp0), 64'(0));
        req0_n(4);
        cyc();
        chk("swap_empty", 64'(emp0), 64'(1));

        // Reset in the middle of a drain
        t256 = mkblk(8'h40, 16);
        load0(t256[127:0]);
        push_blk0(t256[127:0]);
        req0_n(2);
        @(negedge clk);
        #1;
        rstn0 = 1'b0;
        #1;
        chk("midrst_o", 64'(o0), 64'(0));
        chk("midrst_valid", 64'(ov0), 64'(0));
        chk("midrst_empty", 64'(emp0), 64'(1));
        chk("midrst_left_in_queue", 64'(q0.size()), 64'(2));
        q0.delete();
        #1;
        rstn0 = 1'b1;
        cyc();
        req0_n(4);
        t256 = mkblk(8'h50, 16);
        load0(t256[127:0]);
        push_blk0(t256[127:0]);
        req0_n(4);
        cyc();
        chk("postrst_empty", 64'(emp0), 64'(1));

        // Single-slot wide instance; a load during the drain is dropped
        t256 = mkblk(8'h00, 32);
        i1 = t256; wr_en1 = 1'b1; cyc(); wr_en1 = 1'b0;
        chk("u1_full", 64'(wrdy1), 64'(0));
        push1(64'h0706050403020100, 1'b0);
        push1(t256[64 +: 64], 1'b0);
        push1(t256[128 +: 64], 1'b0);
        push1(64'h1F1E1D1C1B1A1918, 1'b1);
        t256 = mkblk(8'h80, 32);
        i1 = t256; wr_en1 = 1'b1; req1 = 1'b1;
        repeat (4) cyc();
        wr_en1 = 1'b0; req1 = 1'b0;
        cyc();
        chk("u1_empty", 64'(emp1), 64'(1));
        chk("u1_ready", 64'(wrdy1), 64'(1));
        req1 = 1'b1; repeat (4) cyc(); req1 = 1'b0;
        cyc();

`ifdef MOD_BLK_SER_FLUSH_EN
        // Flush after one word with a second block queued
        i0 = blk_a; wr_en0 = 1'b1; cyc();
        i0 = blk_b; cyc();
        wr_en0 = 1'b0;
        push0(blk_a[31:0], 1'b0);
        req0_n(1);
        flush0 = 1'b1; req0 = 1'b1; wr_en0 = 1'b1; i0 = blk_c;
        cyc();
        flush0 = 1'b0; req0 = 1'b0; wr_en0 = 1'b0;
        chk("flush_empty", 64'(emp0), 64'(1));
        chk("flush_ready", 64'(wrdy0), 64'(1));
        chk("flush_no_valid", 64'(ov0), 64'(0));
        chk("flush_o_holds", 64'(o0), 64'(32'h03020100));
        req0_n(4);
        t256 = mkblk(8'h20, 16);
        load0(t256[127:0]);
        push0(32'h23222120, 1'b0);
        push0(t256[32 +: 32], 1'b0);
        push0(t256[64 +: 32], 1'b0);
        push0(t256[96 +: 32], 1'b1);
        req0_n(4);
        cyc();
        chk("flush_reload_empty", 64'(emp0), 64'(1));
`endif

        cyc();
        chk("q0_drained", 64'(q0.size()), 64'(0));
        chk("q1_drained", 64'(q1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
